// File: rtl/debounced_input_port_if.sv
// debounced_input_port_if
//   Avalon-MM slave bus for the debounced input port, plus its interrupt.
//   Handshake: a transfer happens on any rising clk edge where chipselect is
//   high together with read or write. There is no wait state. Read data comes
//   back registered one cycle later and holds until the next selected read.
//   Ports (modports):
//     master: drives address[2:0], chipselect, read, write, writedata[31:0];
//             receives readdata[31:0], irq
//     slave : the mirror image
interface debounced_input_port_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;

   modport master (
      output address, chipselect, read, write, writedata,
      input  readdata, irq
   );

   modport slave (
      input  address, chipselect, read, write, writedata,
      output readdata, irq
   );
endinterface

// File: rtl/debounced_input_port.sv
// debounced_input_port
//   Memory-mapped input port for pushbuttons and slide switches. Each channel
//   is optionally inverted and then passed through a 2-FF synchroniser. A
//   per-channel stability counter debounces it, and rising/falling edges are
//   captured under software enables. A masked, level-sensitive interrupt is
//   raised from the captured edges.
//   Ports:
//     clk      : single clock, rising edge
//     reset_n  : asynchronous active-low reset, clears all state
//     in_port  : raw asynchronous inputs, WIDTH bits
//     bus      : Avalon-MM slave (address/chipselect/read/write/writedata,
//                registered readdata) plus irq
//   Register map (word address, bits above WIDTH read 0):
//     0 DATA (RO, debounced)  1 RISE_EN  2 FALL_EN  3 IRQ_MASK
//     4 EDGE_CAP (W1C)        5 RAW (RO, synchronised)  6,7 read 0
module debounced_input_port #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int INPUT_INVERT    = 0
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [WIDTH-1:0]       in_port,
   debounced_input_port_if.slave  bus
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   // Counter value at which the next unstable cycle accepts the new level.
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0]          in_cond;
   logic [WIDTH-1:0]          sync1;
   logic [WIDTH-1:0]          sync;
   logic [WIDTH-1:0]          stable;
   logic [WIDTH-1:0]          stable_next;
   logic [WIDTH-1:0][CW-1:0]  cnt;
   logic [WIDTH-1:0]          rise_en;
   logic [WIDTH-1:0]          fall_en;
   logic [WIDTH-1:0]          irq_mask;
   logic [WIDTH-1:0]          edge_cap;
   logic [WIDTH-1:0]          edge_set;
   logic [WIDTH-1:0]          edge_clr;
   logic [WIDTH-1:0]          wdata;
   logic [31:0]               rd_mux;
   logic [31:0]               readdata_q;
   logic                      irq_q;
   logic                      wr_en;
   logic                      rd_en;
   logic                      unused_wdata;

   assign in_cond = (INPUT_INVERT != 0) ? ~in_port : in_port;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= '0;
         sync  <= '0;
      end else begin
         sync1 <= in_cond;
         sync  <= sync1;
      end
   end

   // Per-channel debounce. The counter runs only while sync differs from
   // stable. On the cycle it would reach DEBOUNCE_CYCLES it clears and the
   // new level is accepted, so it never wraps.
   for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      logic differs;
      logic accept;
      assign differs        = sync[i] != stable[i];
      assign accept         = differs && (cnt[i] == CNT_LAST);
      assign stable_next[i] = accept ? sync[i] : stable[i];

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n)
            cnt[i] <= '0;
         else if (!differs || accept)
            cnt[i] <= '0;
         else
            cnt[i] <= cnt[i] + 1'b1;
      end
   end

   // Edges come from the stable level about to be registered, so the capture
   // lands on the same edge as the stable update.
   assign edge_set = (stable_next & ~stable & rise_en) |
                     (~stable_next & stable & fall_en);

   assign wr_en    = bus.chipselect & bus.write;
   assign rd_en    = bus.chipselect & bus.read;
   assign wdata    = bus.writedata[WIDTH-1:0];
   assign edge_clr = (wr_en && bus.address == 3'd4) ? wdata : '0;
   assign unused_wdata = ^bus.writedata;

   always_comb begin
      rd_mux = '0;
      case (bus.address)
         3'd0:    rd_mux[WIDTH-1:0] = stable;
         3'd1:    rd_mux[WIDTH-1:0] = rise_en;
         3'd2:    rd_mux[WIDTH-1:0] = fall_en;
         3'd3:    rd_mux[WIDTH-1:0] = irq_mask;
         3'd4:    rd_mux[WIDTH-1:0] = edge_cap;
         3'd5:    rd_mux[WIDTH-1:0] = sync;
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable     <= '0;
         rise_en    <= '0;
         fall_en    <= '0;
         irq_mask   <= '0;
         edge_cap   <= '0;
         readdata_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         stable <= stable_next;
         // Set is ORed in after the clear so a same-cycle edge survives W1C.
         edge_cap <= (edge_cap & ~edge_clr) | edge_set;
         if (wr_en && bus.address == 3'd1) rise_en  <= wdata;
         if (wr_en && bus.address == 3'd2) fall_en  <= wdata;
         if (wr_en && bus.address == 3'd3) irq_mask <= wdata;
         if (rd_en) readdata_q <= rd_mux;
         irq_q <= |(edge_cap & irq_mask);
      end
   end

   assign bus.readdata = readdata_q;
   assign bus.irq      = irq_q;

endmodule

// File: doc/debounced_input_port.md
# debounced_input_port

Parametrised, Avalon-MM-mapped input port for pushbuttons and slider switches, replacing fixed-width PIO input ports. Each of `WIDTH` channels is synchronised, debounced by a per-channel stability counter, and edge-detected with software-selectable rising/falling capture. A masked, level-sensitive interrupt goes to the processor. The block sits on the system bus beside the LED and HEX output ports.

## Interface
- `WIDTH`, 4: number of input channels, 1..32.
- `DEBOUNCE_CYCLES`, 50000: consecutive stable cycles required before a change is accepted; must be ≥1.
- `INPUT_INVERT`, 0: if 1, all inputs are inverted before synchronisation (active-low buttons).
- `clk` input 1: single clock, all logic on rising edge.
- `reset_n` input 1: asynchronous assert, active-low; clears all state.
- `in_port` input WIDTH: raw asynchronous switch/button inputs.
- `address` input 3: word address.
- `chipselect` input 1: slave select.
- `read` input 1: read strobe.
- `write` input 1: write strobe.
- `writedata` input 32: write data.
- `readdata` output 32: registered read data.
- `irq` output 1: interrupt, active-high.

## Operation
- Input path: optional invert, then 2-FF synchroniser per channel (`sync`).
- Debounce, per channel: counter of width clog2(DEBOUNCE_CYCLES+1).
  - Counter clears whenever `sync == stable`.
  - Otherwise the counter increments. When it would reach DEBOUNCE_CYCLES, `stable` takes `sync` and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes `stable`.
- Edge detect: when `stable` changes 0→1 and `RISE_EN[i]` is set, `EDGE_CAP[i]` is set in the same cycle. The same applies to 1→0 with `FALL_EN[i]`.
- Register map (bits above WIDTH read 0 and ignore writes):
  - 0 DATA: RO, `stable`.
  - 1 RISE_EN: RW.
  - 2 FALL_EN: RW.
  - 3 IRQ_MASK: RW.
  - 4 EDGE_CAP: reads captured edges. Writing 1 clears the bit; writing 0 leaves it unchanged.
  - 5 RAW: RO, `sync`.
  - 6, 7: read 0, writes ignored.
- Simultaneous set and W1C clear on the same bit: set wins, and the bit stays 1.
- `irq` is a register equal to the previous cycle's OR-reduction of `EDGE_CAP & IRQ_MASK`. It is level-sensitive and remains high until the causing bits are cleared or masked.
- Writes without `chipselect` are ignored. Reads without `chipselect` leave `readdata` unchanged.

## Timing
- Reset values: `readdata`=0, `irq`=0, and all registers, synchronisers, counters and `stable` = 0.
- If an input is held high at reset release, it produces an accepted rising edge after the normal latency.
- Input latency: `in_port` changes before edge N. `sync` reflects the change after edge N+1. `stable` and `EDGE_CAP` update at edge N+1+DEBOUNCE_CYCLES.
- `irq` rises one edge after `EDGE_CAP`, at edge N+2+DEBOUNCE_CYCLES.
- Read latency is 1: with `chipselect & read` at edge K, `readdata` is valid after edge K and held until the next read.
- Write takes effect at the strobe edge, and the new value is visible to a read issued on the following cycle.
- A mask or clear write affects `irq` one edge later.
- Counter never wraps, because it clears at DEBOUNCE_CYCLES.
- With DEBOUNCE_CYCLES=1, `stable` follows `sync` with one cycle of delay.
- Asserting `reset_n` low mid-debounce or mid-transaction clears everything immediately. No partial write survives.

## Test plan
- Reset with WIDTH=4, DEBOUNCE_CYCLES=4, `in_port`=0000 → `readdata`=0, `irq`=0. Reading DATA returns 0.
- Set RISE_EN=0xF and IRQ_MASK=0x1, then hold `in_port[0]`=1 → `stable[0]` is set 6 edges after the change and `irq`=1 on the 7th. Reading EDGE_CAP returns 0x1.
- Pulse `in_port[1]` high for 3 cycles with RISE_EN=0xF → DATA stays 0, EDGE_CAP[1]=0, and the pulse is visible on RAW only.
- Set FALL_EN=0x4 and RISE_EN=0, then toggle `in_port[2]` 0→1→0 with each level held 10 cycles → only the falling edge is captured, and EDGE_CAP reads 0x4.
- With EDGE_CAP=0x1 and `irq`=1, write 0x1 to address 4 → `irq`=0 one edge later. Repeat with the W1C landing on the same cycle as a new edge → bit remains 1 and `irq` stays 1.
- Assert `reset_n` low while a counter is at 3/4 → on release DATA=0, no edge is captured, and debouncing restarts from 0.
